// File: rtl/shield_ram_burst_reader.sv
// Burst read engine for the synchronous shield_ram read port: one command becomes sequential reads
// delivered on a valid/ready stream. Define SHIELD_RAM_READER_PERF_EN to build the beat/stall counters.
module shield_ram_burst_reader #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [31:0]           perf_beats,
  output logic [31:0]           perf_stalls
);

  // Handshake rule on both streams: a transfer happens on a rising edge where valid and ready are
  // both 1; once out_valid is up it stays up with out_data/out_last frozen until out_ready is seen.

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_d [2];
  logic [1:0]            fifo_last_q, fifo_last_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            credit_used;

  assign out_valid   = (count_q != 2'd0);
  assign out_data    = fifo_data_q[rd_ptr_q];
  assign out_last    = out_valid & fifo_last_q[rd_ptr_q];
  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign pop         = out_valid & out_ready;
  assign push        = inflight_q;

  // Slots already spoken for: buffered beats plus the one in the RAM pipe, minus the beat leaving now.
  assign credit_used = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue       = (state_q == READ) && (credit_used < 3'd2);

  // The RAM samples its address on the edge, so the issuing address must be combinational.
  assign ram_rd_addr = issue ? cur_addr_q : rd_addr_q;

  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    rd_addr_d       = rd_addr_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = issue && (remaining_q == '0);
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q + {1'b0, push} - {1'b0, pop};

    if (push) begin
      fifo_data_d[wr_ptr_q] = ram_rd_data;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cur_addr_d  = cmd_addr;
          remaining_d = cmd_len;
          state_d     = READ;
        end
      end
      READ: begin
        if (issue) begin
          rd_addr_d   = cur_addr_q;
          cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == '0) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Leave as soon as the final beat is handed off so a new command can land next cycle.
        if ((count_d == 2'd0) && !inflight_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cur_addr_q      <= '0;
      rd_addr_q       <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q     <= '{default: '0};
      fifo_last_q     <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      cur_addr_q      <= cur_addr_d;
      rd_addr_q       <= rd_addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
    end
  end

`ifdef SHIELD_RAM_READER_PERF_EN
  logic [31:0] perf_beats_q, perf_beats_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_beats_d  = perf_beats_q;
    perf_stalls_d = perf_stalls_q;
    if (pop && (perf_beats_q != 32'hFFFF_FFFF)) begin
      perf_beats_d = perf_beats_q + 32'd1;
    end
    if (out_valid && !out_ready && (perf_stalls_q != 32'hFFFF_FFFF)) begin
      perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_beats_q  <= 32'd0;
      perf_stalls_q <= 32'd0;
    end else begin
      perf_beats_q  <= perf_beats_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_beats  = perf_beats_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_beats  = 32'd0;
  assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_shield_ram_burst_reader.sv
// Self-checking bench for shield_ram_burst_reader: behavioural RAM, scoreboard queue of
// {last, data} beats, latency/throughput checks and perf counter checks.
module tb_shield_ram_burst_reader;

  localparam int DW = 512;
  localparam int AW = 8;
  localparam int LW = 8;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [31:0]   perf_beats;
  logic [31:0]   perf_stalls;

  shield_ram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .perf_beats(perf_beats), .perf_stalls(perf_stalls)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int first_rise_cyc = 0;
  int tb_beats = 0;
  int tb_stalls = 0;
  int ready_mode = 0;
  int ready_idx = 0;
  bit stall_prev = 1'b0;
  logic [DW:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // RAM contents: low byte equals the address, the rest varies per 32-bit lane
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int j = 0; j < DW / 32; j++) w[j*32 +: 32] = {8'h5A, 8'(j), ~a, a};
    return w;
  endfunction

  always @(posedge clk) ram_rd_data <= mem_word(ram_rd_addr);

  task automatic check(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // consumer backpressure driver: 0 always ready, 1 pattern 1,0,0, 2 random
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = (ready_idx % 3 == 0);
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    ready_idx++;
  end

  // scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (rst) begin
      stall_prev = 1'b0;
      tb_beats   = 0;
      tb_stalls  = 0;
    end else begin
      if (out_valid && first_rise_cyc < 0) first_rise_cyc = cyc;
      if (stall_prev) check("stall_valid", {512'd0, out_valid}, 1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", {512'd0, out_valid}, 0);
        end else begin
          check(out_ready ? "beat" : "stall_hold", {out_last, out_data}, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            tb_beats++;
          end
        end
      end
      if (out_valid && !out_ready) tb_stalls++;
      stall_prev = out_valid && !out_ready;
    end
  end

  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge clk);
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_timeout", {512'd0, cmd_ready}, 1);
      cmd_valid = 1'b0;
      return;
    end
    hs_cyc = cyc;
    first_rise_cyc = -1;
    for (int k = 0; k <= int'(l); k++)
      exp_q.push_back({(k == int'(l)), mem_word(AW'(int'(a) + k))});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rd_addr_lat", DW'(ram_rd_addr), DW'(a));
  endtask

  task automatic wait_idle(input bit timing_chk, input int len);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", DW'(exp_q.size()), 0);
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_back", {512'd0, cmd_ready}, 1);
    if (timing_chk) check("cmd_ready_cyc", DW'(cyc - hs_cyc), DW'(len + 4));
    check("first_beat_lat", DW'(first_rise_cyc - hs_cyc), 3);
    check("busy_idle", {512'd0, busy}, 0);
`ifdef SHIELD_RAM_READER_PERF_EN
    check("perf_beats", DW'(perf_beats), DW'(tb_beats));
    check("perf_stalls", DW'(perf_stalls), DW'(tb_stalls));
`else
    check("perf_beats_off", DW'(perf_beats), 0);
    check("perf_stalls_off", DW'(perf_stalls), 0);
`endif
  endtask

  initial begin
    int start;
    int n;
    // reset state
    #2;
    check("rst_out_valid", {512'd0, out_valid}, 0);
    check("rst_out_last", {512'd0, out_last}, 0);
    check("rst_out_data", {1'b0, out_data}, 0);
    check("rst_busy", {512'd0, busy}, 0);
    check("rst_rd_addr", DW'(ram_rd_addr), 0);
    check("rst_perf", DW'({perf_beats, perf_stalls}), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", {512'd0, cmd_ready}, 1);

    // basic burst, wrap-around, single beat, max length
    ready_mode = 0;
    send_cmd(8'h10, 8'd3);   wait_idle(1, 3);
    send_cmd(8'hFE, 8'd3);   wait_idle(1, 3);
    send_cmd(8'h77, 8'd0);   wait_idle(1, 0);
    send_cmd(8'h80, 8'd255); wait_idle(1, 255);

    // command held high across a busy burst
    send_cmd(8'h20, 8'd5);
    start = hs_cyc;
    send_cmd(8'h90, 8'd2);
    check("second_hs_cyc", DW'(hs_cyc - start), DW'(5 + 4));
    wait_idle(1, 2);

    // backpressure: fixed pattern then random
    ready_mode = 1;
    send_cmd(8'h50, 8'd7);  wait_idle(0, 7);
    ready_mode = 2;
    for (int t = 0; t < 4; t++) begin
      send_cmd(AW'($urandom_range(0, 255)), LW'($urandom_range(0, 40)));
      wait_idle(0, 0);
    end

    // reset in the middle of a 16-beat burst
    ready_mode = 0;
    send_cmd(8'h30, 8'd15);
    start = tb_beats;
    n = 0;
    while (tb_beats < start + 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("busy_mid", {512'd0, busy}, 1);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", {512'd0, out_valid}, 0);
    check("midrst_busy", {512'd0, busy}, 0);
    check("midrst_rd_addr", DW'(ram_rd_addr), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_cmd_ready", {512'd0, cmd_ready}, 1);
    send_cmd(8'h40, 8'd0);
    wait_idle(1, 0);
    repeat (6) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
